// File: rtl/beep_tone_pkg.sv
// ----------------------------------------------------------------------------
// beep_tone_pkg
// Shared constants and types for the tone decoder:
//   NOM        nominal rise-to-rise periods (sys_clk cycles at 50 MHz) for
//              the seven notes, index = note code
//   NOTE_NONE  code reported when no note is locked / period unclassified
//   note_e     symbolic note codes
//   state_e    decoder FSM states
//   in_window  tolerance-window test used by the classifier
// ----------------------------------------------------------------------------
package beep_tone_pkg;

  localparam int         NOTE_NUM  = 7;
  localparam logic [2:0] NOTE_NONE = 3'd7;

  // Packed so that NOM[i] is the nominal period of note code i.
  localparam logic [NOTE_NUM-1:0][31:0] NOM = {
    32'd101214,  // 6 Ti
    32'd113636,  // 5 La
    32'd127551,  // 4 So
    32'd143266,  // 3 Fa
    32'd151515,  // 2 Mi
    32'd170068,  // 1 Ra
    32'd190840   // 0 Do
  };

  typedef enum logic [2:0] {
    NOTE_DO = 3'd0,
    NOTE_RA = 3'd1,
    NOTE_MI = 3'd2,
    NOTE_FA = 3'd3,
    NOTE_SO = 3'd4,
    NOTE_LA = 3'd5,
    NOTE_TI = 3'd6,
    NOTE_NC = 3'd7
  } note_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // True when per lies within +/- (nom >> tol_shift) of nom (inclusive).
  function automatic logic in_window(input logic [31:0] per,
                                     input logic [31:0] nom,
                                     input int          tol_shift);
    logic [31:0] diff;
    diff = (per >= nom) ? (per - nom) : (nom - per);
    return (diff <= (nom >> tol_shift));
  endfunction

endpackage

// File: rtl/note_classifier.sv
// ----------------------------------------------------------------------------
// note_classifier
// Purely combinational: maps a measured period onto the note whose
// tolerance window contains it, or NOTE_NONE when none does.
//   period_i  measured rise-to-rise period in sys_clk cycles
//   code_o    note code 0..6, or 7 when unclassified
// ----------------------------------------------------------------------------
module note_classifier
  import beep_tone_pkg::*;
#(
  parameter int PER_W     = 18,
  parameter int TOL_SHIFT = 6
) (
  input  logic [PER_W-1:0] period_i,
  output logic [2:0]       code_o
);

  logic [31:0] per_ext_s;

  assign per_ext_s = 32'(period_i);

  // The windows are disjoint, so at most one index can match.
  always_comb begin
    code_o = NOTE_NONE;
    for (int i = 0; i < NOTE_NUM; i++) begin
      code_o = in_window(per_ext_s, NOM[i], TOL_SHIFT) ? 3'(i) : code_o;
    end
  end

endmodule

// File: rtl/tone_decoder.sv
// ----------------------------------------------------------------------------
// tone_decoder
// Measures the rise-to-rise period of an asynchronous square-wave tone and
// locks onto one of seven notes once STABLE_CNT consecutive periods agree.
//   sys_clk     system clock (50 MHz)
//   sys_rst_n   asynchronous active-low reset
//   tone_in     asynchronous tone input, idles high
//   note_valid  high while a note is locked
//   note_code   locked note 0..6, 7 when none
//   note_stb    one-cycle pulse on each entry to LOCKED
//   period      last measured rise-to-rise period (held through IDLE)
// ----------------------------------------------------------------------------
module tone_decoder
  import beep_tone_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int TOL_SHIFT  = 6,
  parameter int PER_W      = 18
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tone_in,
  output logic             note_valid,
  output logic [2:0]       note_code,
  output logic             note_stb,
  output logic [PER_W-1:0] period
);

  localparam int               MC_W       = $clog2(STABLE_CNT + 1);
  localparam logic [PER_W-1:0] PER_MAX    = {PER_W{1'b1}};
  localparam logic [MC_W-1:0]  MATCH_LOCK = MC_W'(STABLE_CNT);

  logic [1:0]       sync_q;
  logic             dly_q;
  logic             rise_s;
  logic             sat_s;
  logic             eval_q;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [2:0]       class_s;
  state_e           state_q, state_d;
  logic [2:0]       cand_q, cand_d;
  logic [MC_W-1:0]  match_q, match_d;
  logic [2:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             stb_q, stb_d;

  // Reset to 1 so a tone held high across reset release gives no false rise.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= 2'b11;
      dly_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], tone_in};
      dly_q  <= sync_q[1];
    end
  end

  assign rise_s = sync_q[1] & ~dly_q;
  assign sat_s  = (per_cnt_q == PER_MAX);

  // Period counter and captured period; a rise always wins over saturation.
  always_comb begin
    per_cnt_d = per_cnt_q;
    period_d  = period_q;
    if (rise_s) begin
      per_cnt_d = {PER_W{1'b0}};
      period_d  = sat_s ? PER_MAX : (per_cnt_q + PER_W'(1));
    end else if (!sat_s) begin
      per_cnt_d = per_cnt_q + PER_W'(1);
    end else begin
      per_cnt_d = per_cnt_q;
    end
  end

  note_classifier #(
    .PER_W     (PER_W),
    .TOL_SHIFT (TOL_SHIFT)
  ) u_classifier (
    .period_i (period_q),
    .code_o   (class_s)
  );

  // Decoder FSM; evaluates one cycle after a rise, once period_q is fresh.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    match_d = match_q;
    code_d  = code_q;
    valid_d = valid_q;
    stb_d   = 1'b0;
    if (sat_s && !rise_s) begin
      // Tone lost: no rise for the full counter range.
      state_d = ST_IDLE;
      cand_d  = NOTE_NONE;
      match_d = {MC_W{1'b0}};
      code_d  = NOTE_NONE;
      valid_d = 1'b0;
    end else if (eval_q) begin
      case (state_q)
        ST_IDLE: begin
          // First rise only starts a measurement; its period is meaningless.
          state_d = ST_MEASURE;
          cand_d  = NOTE_NONE;
          match_d = {MC_W{1'b0}};
        end
        ST_MEASURE: begin
          if (class_s == NOTE_NONE) begin
            match_d = {MC_W{1'b0}};
          end else begin
            cand_d  = class_s;
            match_d = (class_s == cand_q) ? (match_q + MC_W'(1)) : MC_W'(1);
            if (match_d >= MATCH_LOCK) begin
              state_d = ST_LOCKED;
              code_d  = class_s;
              valid_d = 1'b1;
              stb_d   = 1'b1;
            end else begin
              state_d = ST_MEASURE;
            end
          end
        end
        ST_LOCKED: begin
          if (class_s == code_q) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_MEASURE;
            valid_d = 1'b0;
            code_d  = NOTE_NONE;
            cand_d  = class_s;
            match_d = (class_s != NOTE_NONE) ? MC_W'(1) : {MC_W{1'b0}};
          end
        end
        default: begin
          state_d = ST_IDLE;
          cand_d  = NOTE_NONE;
          match_d = {MC_W{1'b0}};
          code_d  = NOTE_NONE;
          valid_d = 1'b0;
        end
      endcase
    end else begin
      stb_d = 1'b0;
    end
  end

  // Counter, period, FSM state and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      per_cnt_q <= {PER_W{1'b0}};
      period_q  <= {PER_W{1'b0}};
      eval_q    <= 1'b0;
      state_q   <= ST_IDLE;
      cand_q    <= NOTE_NONE;
      match_q   <= {MC_W{1'b0}};
      code_q    <= NOTE_NONE;
      valid_q   <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
      eval_q    <= rise_s;
      state_q   <= state_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      stb_q     <= stb_d;
    end
  end

  assign note_valid = valid_q;
  assign note_code  = code_q;
  assign note_stb   = stb_q;
  assign period     = period_q;

endmodule

// File: tb/tb_tone_decoder.sv
module tb_tone_decoder;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        tone_in;
  logic        note_valid;
  logic [2:0]  note_code;
  logic        note_stb;
  logic [17:0] period;

  int          checks;
  int          errors;
  int          stb_cnt;
  logic        v3, v4, s4, pa, pb;
  logic [2:0]  c4;
  logic [17:0] per4;

  tone_decoder dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .tone_in    (tone_in),
    .note_valid (note_valid),
    .note_code  (note_code),
    .note_stb   (note_stb),
    .period     (period)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // One tone period of p cycles: rising drive at offset 0, high for hi cycles.
  // Offset 3 shows outputs before this rise takes effect, offset 4 after.
  // Optional probe pk samples note_valid at offsets pk-1 and pk.
  task automatic tone_period(input int p, input int hi, input int pk);
    for (int j = 0; j < p; j++) begin
      @(negedge sys_clk);
      if (note_stb === 1'b1) stb_cnt++;
      if (j == 3) v3 = note_valid;
      if (j == 4) begin
        v4 = note_valid; c4 = note_code; s4 = note_stb; per4 = period;
      end
      if (pk > 0 && j == pk - 1) pa = note_valid;
      if (pk > 0 && j == pk) pb = note_valid;
      tone_in = (j < hi);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    tone_in   = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", note_valid); end
    checks++; if (note_code !== 3'd7) begin errors++; $display("FAIL rst_code got %0d exp 7", note_code); end
    checks++; if (note_stb !== 1'b0) begin errors++; $display("FAIL rst_stb got %0b exp 0", note_stb); end
    checks++; if (period !== 18'd0) begin errors++; $display("FAIL rst_period got %0d exp 0", period); end
    sys_rst_n = 1'b1;
    repeat (6) @(negedge sys_clk);
    checks++; if (period !== 18'd0) begin errors++; $display("FAIL rst_release_period got %0d exp 0", period); end
    checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid got %0b exp 0", note_valid); end
    tone_in = 1'b0;
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic test_lock_do();
    stb_cnt = 0;
    repeat (4) tone_period(190840, 95420, 0);
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL do_4th_valid got %0b exp 0", v4); end
    tone_period(190840, 95420, 0);
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL do_latency_early got %0b exp 0", v3); end
    checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL do_valid got %0b exp 1", v4); end
    checks++; if (c4 !== 3'd0) begin errors++; $display("FAIL do_code got %0d exp 0", c4); end
    checks++; if (s4 !== 1'b1) begin errors++; $display("FAIL do_stb got %0b exp 1", s4); end
    checks++; if (per4 !== 18'd190840) begin errors++; $display("FAIL do_period got %0d exp 190840", per4); end
    checks++; if (stb_cnt !== 1) begin errors++; $display("FAIL do_stb_count got %0d exp 1", stb_cnt); end
  endtask

  task automatic test_switch_ra();
    stb_cnt = 0;
    tone_period(170068, 85034, 0);
    checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL ra_hold_valid got %0b exp 1", v4); end
    checks++; if (per4 !== 18'd190840) begin errors++; $display("FAIL ra_hold_period got %0d exp 190840", per4); end
    tone_period(170068, 85034, 0);
    checks++; if (v3 !== 1'b1) begin errors++; $display("FAIL ra_drop_early got %0b exp 1", v3); end
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL ra_drop_valid got %0b exp 0", v4); end
    checks++; if (c4 !== 3'd7) begin errors++; $display("FAIL ra_drop_code got %0d exp 7", c4); end
    checks++; if (per4 !== 18'd170068) begin errors++; $display("FAIL ra_drop_period got %0d exp 170068", per4); end
    repeat (2) tone_period(170068, 85034, 0);
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL ra_3rd_valid got %0b exp 0", v4); end
    // Shortened period: its length feeds the glitch scenario.
    tone_period(120000, 85034, 0);
    checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL ra_lock_valid got %0b exp 1", v4); end
    checks++; if (c4 !== 3'd1) begin errors++; $display("FAIL ra_lock_code got %0d exp 1", c4); end
    checks++; if (stb_cnt !== 1) begin errors++; $display("FAIL ra_stb_count got %0d exp 1", stb_cnt); end
  endtask

  task automatic test_glitch();
    tone_period(50068, 1, 0);
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL glitch_drop_valid got %0b exp 0", v4); end
    checks++; if (per4 !== 18'd120000) begin errors++; $display("FAIL glitch_period got %0d exp 120000", per4); end
    tone_period(170068, 85034, 0);
    checks++; if (per4 !== 18'd50068) begin errors++; $display("FAIL glitch_rest_period got %0d exp 50068", per4); end
    repeat (3) tone_period(170068, 85034, 0);
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL glitch_3clean_valid got %0b exp 0", v4); end
    tone_period(193821, 96910, 0);
    checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL glitch_relock_valid got %0b exp 1", v4); end
    checks++; if (c4 !== 3'd1) begin errors++; $display("FAIL glitch_relock_code got %0d exp 1", c4); end
  endtask

  task automatic test_tolerance();
    tone_period(193821, 96910, 0);
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL tol_drop_valid got %0b exp 0", v4); end
    checks++; if (per4 !== 18'd193821) begin errors++; $display("FAIL tol_edge_period got %0d exp 193821", per4); end
    repeat (2) tone_period(193821, 96910, 0);
    // Final rise locks; tone then stays high long enough to time out.
    tone_period(262300, 262290, 262147);
    checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL tol_edge_valid got %0b exp 1", v4); end
    checks++; if (c4 !== 3'd0) begin errors++; $display("FAIL tol_edge_code got %0d exp 0", c4); end
  endtask

  task automatic test_timeout();
    checks++; if (pa !== 1'b1) begin errors++; $display("FAIL tmo_before got %0b exp 1", pa); end
    checks++; if (pb !== 1'b0) begin errors++; $display("FAIL tmo_after got %0b exp 0", pb); end
    stb_cnt = 0;
    tone_period(190840, 95420, 0);
    checks++; if (per4 !== 18'd262143) begin errors++; $display("FAIL tmo_sat_period got %0d exp 262143", per4); end
    checks++; if (c4 !== 3'd7) begin errors++; $display("FAIL tmo_idle_code got %0d exp 7", c4); end
    repeat (3) tone_period(190840, 95420, 0);
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL tmo_4th_valid got %0b exp 0", v4); end
    tone_period(190840, 95420, 0);
    checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL tmo_relock_valid got %0b exp 1", v4); end
    checks++; if (s4 !== 1'b1) begin errors++; $display("FAIL tmo_relock_stb got %0b exp 1", s4); end
    checks++; if (stb_cnt !== 1) begin errors++; $display("FAIL tmo_stb_count got %0d exp 1", stb_cnt); end
  endtask

  task automatic test_reset_mid_lock();
    @(negedge sys_clk);
    tone_in = 1'b1;
    #2 sys_rst_n = 1'b0;
    #1;
    checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %0b exp 0", note_valid); end
    checks++; if (note_code !== 3'd7) begin errors++; $display("FAIL mrst_code got %0d exp 7", note_code); end
    checks++; if (period !== 18'd0) begin errors++; $display("FAIL mrst_period got %0d exp 0", period); end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    stb_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge sys_clk);
      if (note_stb === 1'b1) stb_cnt++;
    end
    checks++; if (stb_cnt !== 0) begin errors++; $display("FAIL mrst_stb_count got %0d exp 0", stb_cnt); end
    checks++; if (period !== 18'd0) begin errors++; $display("FAIL mrst_no_rise got %0d exp 0", period); end
    tone_in = 1'b0;
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic test_never_valid();
    stb_cnt = 0;
    tone_period(193822, 96911, 0);
    tone_period(195000, 97500, 0);
    checks++; if (per4 !== 18'd193822) begin errors++; $display("FAIL nv_a_period got %0d exp 193822", per4); end
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL nv_a_valid got %0b exp 0", v4); end
    tone_period(193822, 96911, 0);
    checks++; if (per4 !== 18'd195000) begin errors++; $display("FAIL nv_b_period got %0d exp 195000", per4); end
    checks++; if (c4 !== 3'd7) begin errors++; $display("FAIL nv_b_code got %0d exp 7", c4); end
    tone_period(10, 5, 0);
    checks++; if (per4 !== 18'd193822) begin errors++; $display("FAIL nv_c_period got %0d exp 193822", per4); end
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL nv_c_valid got %0b exp 0", v4); end
    checks++; if (stb_cnt !== 0) begin errors++; $display("FAIL nv_stb_count got %0d exp 0", stb_cnt); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    stb_cnt = 0;
    v3 = 1'b0; v4 = 1'b0; s4 = 1'b0; pa = 1'b0; pb = 1'b0;
    c4 = 3'd0; per4 = 18'd0;
    test_reset();
    test_lock_do();
    test_switch_ra();
    test_glitch();
    test_tolerance();
    test_timeout();
    test_reset_mid_lock();
    test_never_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, the number of consecutive same-note periods required to lock.
REQ-002 SHALL have parameter TOL_SHIFT, default 6, which sets the match tolerance to ±(nominal >> TOL_SHIFT) cycles.
REQ-003 SHALL have parameter PER_W, default 18, the period counter width; the timeout is 2^PER_W-1 = 262_143 cycles.
REQ-004 sys_clk  in  1  system clock, 50 MHz.
REQ-005 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 tone_in  in  1  asynchronous square-wave tone; idles high.
REQ-007 note_valid  out  1  high while a note is locked.
REQ-008 note_code  out  3  0=Do, 1=Ra, 2=Mi, 3=Fa, 4=So, 5=La, 6=Ti, 7=none.
REQ-009 note_stb  out  1  one-cycle pulse on each entry to LOCKED.
REQ-010 period  out  PER_W  last measured rise-to-rise period in sys_clk cycles.

Function
REQ-011 tone_in SHALL pass through a 2-FF synchronizer plus one delay FF; rise = sync & ~delayed, high for exactly one cycle.
REQ-012 per_cnt SHALL clear to 0 on rise, else increment, and saturate at 2^PER_W-1.
REQ-013 On rise, the period register SHALL load min(per_cnt+1, 2^PER_W-1).
REQ-014 The classifier SHALL map period to index i when |period - NOM[i]| <= NOM[i]>>TOL_SHIFT, else to 7.
REQ-015 Nominal periods NOM[0..6] SHALL be 190_840, 170_068, 151_515, 143_266, 127_551, 113_636, 101_214; the windows are disjoint.
REQ-016 The FSM SHALL have states IDLE, MEASURE and LOCKED, and SHALL evaluate on the cycle after rise using the classification c of the new period.
REQ-017 IDLE: the first rise SHALL go to MEASURE with cand=7 and match_cnt=0; this rise produces no period evaluation.
REQ-018 MEASURE, c=7: match_cnt SHALL become 0.
REQ-019 MEASURE, c=cand: match_cnt SHALL increment.
REQ-020 MEASURE, c!=cand and c!=7: cand SHALL become c and match_cnt SHALL become 1.
REQ-021 When match_cnt reaches STABLE_CNT, the FSM SHALL go to LOCKED, set note_code=cand and note_valid=1, and pulse note_stb.
REQ-022 LOCKED, c=note_code: the FSM SHALL stay in LOCKED with no note_stb.
REQ-023 LOCKED, c!=note_code: the FSM SHALL go to MEASURE with note_valid=0 and note_code=7; cand=c, and match_cnt=1 when c!=7, else 0.
REQ-024 per_cnt saturated with no rise in that cycle SHALL send any state to IDLE: note_valid=0, note_code=7, cand cleared.
REQ-025 Rise coincident with saturation: rise SHALL win; the period is evaluated as 262_143 and classifies to 7.
REQ-026 note_valid, note_code and note_stb SHALL be registered and SHALL change exactly 2 cycles after the rise cycle that caused the change.
REQ-027 period SHALL update 1 cycle after rise and SHALL hold its value through IDLE.

Reset
REQ-028 Reset SHALL set: synchronizer and delay FFs=1 (no false rise after release), per_cnt=0, period=0, state=IDLE, cand=7, match_cnt=0, note_valid=0, note_code=7, note_stb=0.
REQ-029 Reset asserted mid-operation SHALL force these values immediately, independent of sys_clk.

Structure
REQ-030 Package beep_tone_pkg SHALL hold NOM[0..6], NOTE_NONE=3'd7, the note-code enum and the FSM state typedef.
REQ-031 The window comparison SHALL be the sub-module note_classifier: combinational, input period, output 3-bit code, TOL_SHIFT passed down.

Verification
REQ-032 Reset, then tone period 190_840 at 50% duty -> note_valid=1 and note_code=0 two cycles after the 5th rise; one note_stb pulse; period=190_840.
REQ-033 Locked Do, then switch to 170_068 -> note_valid=0 two cycles after the first Ra-period rise; relock with code 1 after the 4th Ra period; period=170_068.
REQ-034 Periods of 193_821 -> locks code 0; periods of 193_822 and 195_000 -> never valid, period shows the value.
REQ-035 Locked, then tone_in held high -> note_valid=0 and IDLE once per_cnt saturates (262_143 cycles after the last rise); on resume, 5 rises are needed to relock.
REQ-036 Locked, then a 1-cycle high glitch mid-period -> lock drops (short period classifies to 7); relock after STABLE_CNT clean periods.
REQ-037 Reset asserted mid-lock with tone_in high at release -> outputs at reset values immediately; no rise and no note_stb after release.
